// File: rtl/dht11_emulador.sv
// DHT11 responder: detects the host start pulse, answers with the presence
// sequence and shifts out a 40-bit humidity/temperature/checksum frame.
module dht11_emulador #(
    parameter int CICLOS_US      = 50,
    parameter int T_START_MIN_US = 18000,
    parameter int T_ESPERA_US    = 30,
    parameter int T_RESP_US      = 80,
    parameter int T_BIT_BAIXO_US = 50,
    parameter int T_BIT0_US      = 27,
    parameter int T_BIT1_US      = 70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] umidade_int,
    input  logic [7:0] umidade_dec,
    input  logic [7:0] temperatura_int,
    input  logic [7:0] temperatura_dec,
    input  logic       erro_checksum,
    input  logic       dht_in,
    output logic       dht_drive_low,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int CW = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        MEDE_START = 4'd1,
        ESPERA     = 4'd2,
        RESP_BAIXO = 4'd3,
        RESP_ALTO  = 4'd4,
        BIT_BAIXO  = 4'd5,
        BIT_ALTO   = 4'd6,
        FIM_BAIXO  = 4'd7,
        FIM        = 4'd8
    } estado_t;

    estado_t       estado;
    estado_t       prox;
    logic          sinc1;
    logic          b;
    logic [CW-1:0] cnt_ciclo;
    logic [15:0]   cnt_us;
    logic [15:0]   dur_us;
    logic [39:0]   quadro;
    logic [5:0]    indice;
    logic [7:0]    soma;
    logic [7:0]    checksum;
    logic          tick;
    logic          expirou;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1 <= 1'b1;
            b     <= 1'b1;
        end else begin
            sinc1 <= dht_in;
            b     <= sinc1;
        end
    end

    assign soma     = umidade_int + umidade_dec + temperatura_int + temperatura_dec;
    assign checksum = erro_checksum ? ~soma : soma;
    assign tick     = (cnt_ciclo == CW'(CICLOS_US - 1));
    assign expirou  = tick && (cnt_us == dur_us - 16'd1);

    always_comb begin
        dur_us = 16'd0;
        case (estado)
            ESPERA:                dur_us = 16'(T_ESPERA_US);
            RESP_BAIXO, RESP_ALTO: dur_us = 16'(T_RESP_US);
            BIT_BAIXO, FIM_BAIXO:  dur_us = 16'(T_BIT_BAIXO_US);
            BIT_ALTO:              dur_us = quadro[39] ? 16'(T_BIT1_US) : 16'(T_BIT0_US);
            default:               dur_us = 16'd0;
        endcase
    end

    // b is only consulted while idle or measuring, so our own drive cannot retrigger
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:     if (habilita && !b) prox = MEDE_START;
            MEDE_START: begin
                if (!habilita)
                    prox = OCIOSO;
                else if (b)
                    prox = (cnt_us >= 16'(T_START_MIN_US)) ? ESPERA : OCIOSO;
            end
            ESPERA:     if (expirou) prox = RESP_BAIXO;
            RESP_BAIXO: if (expirou) prox = RESP_ALTO;
            RESP_ALTO:  if (expirou) prox = BIT_BAIXO;
            BIT_BAIXO:  if (expirou) prox = BIT_ALTO;
            BIT_ALTO:   if (expirou) prox = (indice == 6'd39) ? FIM_BAIXO : BIT_BAIXO;
            FIM_BAIXO:  if (expirou) prox = FIM;
            FIM:        prox = OCIOSO;
            default:    prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            cnt_ciclo <= '0;
            cnt_us    <= '0;
            quadro    <= '0;
            indice    <= '0;
        end else begin
            estado <= prox;
            // Timers restart on every state entry; the us count saturates for a held-low bus
            if (prox != estado) begin
                cnt_ciclo <= '0;
                cnt_us    <= '0;
            end else if (tick) begin
                cnt_ciclo <= '0;
                if (cnt_us != 16'hFFFF)
                    cnt_us <= cnt_us + 16'd1;
            end else begin
                cnt_ciclo <= cnt_ciclo + CW'(1);
            end
            if (estado == MEDE_START && prox == ESPERA) begin
                quadro <= {umidade_int, umidade_dec, temperatura_int, temperatura_dec, checksum};
                indice <= '0;
            end else if (estado == BIT_ALTO && prox != BIT_ALTO) begin
                quadro <= {quadro[38:0], 1'b0};
                indice <= indice + 6'd1;
            end
        end
    end

    assign dht_drive_low = (estado == RESP_BAIXO) || (estado == BIT_BAIXO) || (estado == FIM_BAIXO);
    assign ocupado       = (estado >= ESPERA) && (estado <= FIM_BAIXO);
    assign pronto        = (estado == FIM);
    assign db_estado     = estado;

endmodule

// File: tb/tb_dht11_emulador.sv
// Directed bench for dht11_emulador: acts as the host, decodes the frame from
// the bus and compares against hand-computed frames and durations.
module tb_dht11_emulador;

    // Scaled clock and start threshold keep the run short; frame timings stay nominal.
    localparam int C      = 2;
    localparam int TMIN   = 300;
    localparam int TESP   = 30;
    localparam int TRESP  = 80;
    localparam int TBB    = 50;
    localparam int T0     = 27;
    localparam int T1     = 70;
    localparam int HLONG  = TMIN + 60;
    localparam int HSHORT = 170;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilita;
    logic       erro_checksum;
    logic       host_rel;
    logic [7:0] umidade_int, umidade_dec, temperatura_int, temperatura_dec;
    logic       dht_drive_low, ocupado, pronto;
    logic [3:0] db_estado;
    logic       dht_in;

    int errors = 0;
    int checks = 0;
    logic [39:0] exp_q[$];

    assign dht_in = host_rel & ~dht_drive_low;

    dht11_emulador #(
        .CICLOS_US(C), .T_START_MIN_US(TMIN), .T_ESPERA_US(TESP), .T_RESP_US(TRESP),
        .T_BIT_BAIXO_US(TBB), .T_BIT0_US(T0), .T_BIT1_US(T1)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita),
        .umidade_int(umidade_int), .umidade_dec(umidade_dec),
        .temperatura_int(temperatura_int), .temperatura_dec(temperatura_dec),
        .erro_checksum(erro_checksum), .dht_in(dht_in),
        .dht_drive_low(dht_drive_low), .ocupado(ocupado), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nominal frame length in us from response start to end of the final low.
    function automatic int frame_us(input logic [39:0] f);
        int s;
        s = 2 * TRESP + 40 * TBB + TBB;
        for (int i = 0; i < 40; i++) s += f[i] ? T1 : T0;
        return s;
    endfunction

    task automatic host_start(input int low_us);
        @(negedge clock);
        host_rel = 1'b0;
        repeat (low_us * C) @(negedge clock);
        host_rel = 1'b1;
    endtask

    // Decodes one frame from the released-time of each bit; can drop habilita
    // or overwrite the input bytes once a given number of bits has gone out.
    task automatic capture_frame(input int drop_bit, input int chg_bit, output logic [39:0] data,
                                 output int lat, output int flen, output bit tout);
        int hlen, nbits, t;
        logic prev;
        tout = 1'b0; lat = 0; flen = 0; data = '0; nbits = -1; hlen = 0;
        while (dht_drive_low !== 1'b1 && lat < 2000) begin
            @(negedge clock);
            lat++;
        end
        if (dht_drive_low !== 1'b1) begin
            tout = 1'b1;
            return;
        end
        prev = 1'b1;
        t = 0;
        while (pronto !== 1'b1 && t < 20000) begin
            @(negedge clock);
            t++;
            if (!dht_drive_low) begin
                hlen = prev ? 1 : hlen + 1;
            end else if (!prev) begin
                if (nbits >= 0) data = {data[38:0], (hlen > 48 * C)};
                nbits++;
                if (nbits == drop_bit) habilita = 1'b0;
                if (nbits == chg_bit) begin
                    umidade_int = 8'hFF; umidade_dec = 8'hFF;
                    temperatura_int = 8'hFF; temperatura_dec = 8'hFF;
                end
            end
            prev = dht_drive_low;
        end
        flen = t;
        if (pronto !== 1'b1) tout = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int drop_bit, input int chg_bit);
        logic [39:0] data, exp;
        int lat, flen;
        bit tout;
        exp = exp_q.pop_front();
        host_start(HLONG);
        capture_frame(drop_bit, chg_bit, data, lat, flen, tout);
        check({tag, "_timeout"}, 64'(tout), 64'd0);
        check({tag, "_data"}, 64'(data), 64'(exp));
        // lat counts from the release negedge: first edge sees it, then 2 sync edges to ESPERA
        check({tag, "_latency"}, 64'(lat - 1), 64'(TESP * C + 2));
        check({tag, "_len"}, 64'(flen), 64'(frame_us(exp) * C));
        check({tag, "_ocupado_at_pronto"}, 64'(ocupado), 64'd0);
        @(negedge clock);
        check({tag, "_pronto_1cyc"}, 64'(pronto), 64'd0);
        check({tag, "_idle_after"}, 64'(db_estado), 64'd0);
    endtask

    initial begin
        bit seen;
        int n;
        habilita = 1'b1; erro_checksum = 1'b0; host_rel = 1'b1;
        umidade_int = 8'h3C; umidade_dec = 8'h00; temperatura_int = 8'h19; temperatura_dec = 8'h05;

        repeat (3) @(negedge clock);
        check("rst_drive", 64'(dht_drive_low), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_pronto", 64'(pronto), 64'd0);
        check("rst_estado", 64'(db_estado), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        exp_q.push_back(40'h3C0019055A);
        run_frame("basic", -1, -1);

        erro_checksum = 1'b1;
        exp_q.push_back(40'h3C001905A5);
        run_frame("cksum_err", -1, -1);
        erro_checksum = 1'b0;

        // Short host low: measured, then rejected without any response
        @(negedge clock);
        host_rel = 1'b0;
        repeat (20) @(negedge clock);
        check("short_measuring", 64'(db_estado), 64'd1);
        repeat (HSHORT * C - 20) @(negedge clock);
        host_rel = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clock);
            if (dht_drive_low) seen = 1'b1;
        end
        check("short_no_resp", 64'(seen), 64'd0);
        check("short_idle", 64'(db_estado), 64'd0);

        habilita = 1'b0;
        host_start(HLONG);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clock);
            if (dht_drive_low || ocupado) seen = 1'b1;
        end
        check("dis_no_resp", 64'(seen), 64'd0);
        check("dis_idle", 64'(db_estado), 64'd0);
        habilita = 1'b1;

        exp_q.push_back(40'h3C0019055A);
        run_frame("hab_drop", 19, -1);
        habilita = 1'b1;

        exp_q.push_back(40'h3C0019055A);
        run_frame("snapshot", -1, 10);
        exp_q.push_back(40'hFFFFFFFFFC);
        run_frame("all_ff", -1, -1);

        // Asynchronous reset while a bit preamble is driving the bus
        host_start(HLONG);
        n = 0;
        while (db_estado !== 4'd5 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("reach_bit_baixo", 64'(db_estado), 64'd5);
        check("bit_baixo_drive", 64'(dht_drive_low), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_drive", 64'(dht_drive_low), 64'd0);
        check("arst_ocupado", 64'(ocupado), 64'd0);
        check("arst_pronto", 64'(pronto), 64'd0);
        check("arst_estado", 64'(db_estado), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_idle", 64'(db_estado), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
